// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word and status encoding, plus the arbiter's
// state and requester-class enums.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  typedef enum logic {
    ICLASS = 1'b0,
    DCLASS = 1'b1
  } arb_class_t;

  // Width of a core index; a single core still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo CPUS.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter  int CPUS = 2,
  localparam int IW   = idx_width(CPUS)
) (
  input  logic [CPUS-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = CPUS; k >= 1; k--) begin
      pos = IW'((int'(last) + k) % CPUS);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between all icaches and dcaches: dcache before icache,
// round-robin between cores, with a starvation cap guaranteeing fetch progress.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int ISTARVE_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     iload,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  localparam int            IW        = idx_width(CPUS);
  localparam int            SW        = $clog2(ISTARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX      = SW'(ISTARVE_MAX);
  localparam logic [IW-1:0] LAST_INIT = IW'(CPUS - 1);

  arb_state_t    state_reg;
  arb_class_t    grant_class_reg;
  logic [IW-1:0] grant_core_reg;
  logic [IW-1:0] rr_last_reg;
  logic [SW-1:0] starve_cnt_reg;

  logic [CPUS-1:0] dreq;
  logic            any_i, any_d;
  logic [IW-1:0]   ipick_idx, dpick_idx;
  arb_class_t      sel_class;
  logic [IW-1:0]   sel_core;
  logic            g_i_ren, g_d_ren, g_d_wen, g_active;
  logic            serving, ack;

  assign dreq = dREN | dWEN;

  rr_pick #(.CPUS(CPUS)) u_ipick (
    .req   (iREN),
    .last  (rr_last_reg),
    .valid (any_i),
    .idx   (ipick_idx)
  );

  rr_pick #(.CPUS(CPUS)) u_dpick (
    .req   (dreq),
    .last  (rr_last_reg),
    .valid (any_d),
    .idx   (dpick_idx)
  );

  always_comb begin
    if (starve_cnt_reg == SMAX && any_i) begin
      sel_class = ICLASS;
    end else if (any_d) begin
      sel_class = DCLASS;
    end else begin
      sel_class = ICLASS;
    end
    sel_core = (sel_class == DCLASS) ? dpick_idx : ipick_idx;
  end

  // Live view of the granted requester; a dropped request aborts the transfer.
  assign g_i_ren  = iREN[grant_core_reg];
  assign g_d_ren  = dREN[grant_core_reg];
  assign g_d_wen  = dWEN[grant_core_reg];
  assign g_active = (grant_class_reg == ICLASS) ? g_i_ren : (g_d_ren | g_d_wen);
  assign serving  = (state_reg == SERVE);
  assign ack      = serving && g_active && (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      grant_class_reg <= ICLASS;
      grant_core_reg  <= '0;
      rr_last_reg     <= LAST_INIT;
      starve_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_i || any_d) begin
            state_reg       <= SERVE;
            grant_class_reg <= sel_class;
            grant_core_reg  <= sel_core;
          end
        end
        SERVE: begin
          if (!g_active) begin
            state_reg <= IDLE;
          end else if (ramstate == ACCESS) begin
            state_reg   <= IDLE;
            rr_last_reg <= grant_core_reg;
            if (grant_class_reg == ICLASS) begin
              starve_cnt_reg <= '0;
            end else if (any_i) begin
              starve_cnt_reg <= (starve_cnt_reg == SMAX) ? SMAX : starve_cnt_reg + 1'b1;
            end else begin
              starve_cnt_reg <= '0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM drive and waits decode from the latched grant, so reset clears them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (serving) begin
      if (grant_class_reg == ICLASS) begin
        ramREN                = g_i_ren;
        ramaddr               = iaddr[grant_core_reg];
        iwait[grant_core_reg] = ~ack;
      end else begin
        ramWEN  = g_d_wen;
        ramREN  = g_d_ren & ~g_d_wen;
        ramaddr = daddr[grant_core_reg];
        if (g_d_wen) begin
          ramstore = dstore[grant_core_reg];
        end
        dwait[grant_core_reg] = ~ack;
      end
    end
  end

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_load
    assign iload[gi] = ramload;
    assign dload[gi] = ramload;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: hand-derived vector table, directed starvation
// and reset sequences, then randomized traffic against a transaction-level model.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  word_t [1:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  word_t [1:0] iload, dload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int tests = 0;
  int fails = 0;

  cache_mem_arbiter #(.CPUS(CPUS), .ISTARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] iren, dren, dwen;
    ramstate_t  rs;
    logic       ren, wen;
    word_t      addr, store;
    logic [1:0] iw, dw;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                              input ramstate_t rs, input logic ren, input logic wen,
                              input word_t a, input word_t s, input logic [1:0] iwv,
                              input logic [1:0] dwv);
    vec_t v;
    v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs;
    v.ren = ren; v.wen = wen; v.addr = a; v.store = s; v.iw = iwv; v.dw = dwv;
    return v;
  endfunction

  // Drive inputs just after a rising edge, then move to the sampling edge.
  task automatic tick(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                      input ramstate_t rs);
    iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // Transaction-level reference state for the random phase.
  logic       m_busy;
  logic       m_dcls;
  int         m_core, m_last, m_starve;

  function automatic int first_from(input logic [1:0] req, input int last);
    for (int k = 1; k <= CPUS; k++) begin
      if (req[(last + k) % CPUS]) return (last + k) % CPUS;
    end
    return 0;
  endfunction

  initial begin
    logic       e_ren, e_wen, act;
    word_t      e_addr, e_store;
    logic [1:0] e_iw, e_dw;
    logic [1:0] ih, dr_h, dw_h;

    iaddr[0] = 32'h40; iaddr[1] = 32'h44;
    daddr[0] = 32'h80; daddr[1] = 32'h84;
    dstore[0] = 32'h11; dstore[1] = 32'h22;
    ramload = 32'hDEADBEEF;

    vt[0]  = mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[1]  = mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h40, 32'h0,  2'b11, 2'b11);
    vt[2]  = mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h40, 32'h0,  2'b11, 2'b11);
    vt[3]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40, 32'h0,  2'b10, 2'b11);
    vt[4]  = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[5]  = mk(2'b01, 2'b10, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[6]  = mk(2'b01, 2'b10, 2'b00, ACCESS, 1, 0, 32'h84, 32'h0,  2'b11, 2'b01);
    vt[7]  = mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[8]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40, 32'h0,  2'b10, 2'b11);
    vt[9]  = mk(2'b00, 2'b00, 2'b11, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[10] = mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, 32'h84, 32'h22, 2'b11, 2'b01);
    vt[11] = mk(2'b00, 2'b00, 2'b11, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[12] = mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, 32'h80, 32'h11, 2'b11, 2'b10);
    vt[13] = mk(2'b00, 2'b00, 2'b11, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[14] = mk(2'b00, 2'b00, 2'b11, ERROR,  0, 1, 32'h84, 32'h22, 2'b11, 2'b11);
    vt[15] = mk(2'b00, 2'b00, 2'b11, ERROR,  0, 1, 32'h84, 32'h22, 2'b11, 2'b11);
    vt[16] = mk(2'b00, 2'b00, 2'b11, ERROR,  0, 1, 32'h84, 32'h22, 2'b11, 2'b11);
    vt[17] = mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, 32'h84, 32'h22, 2'b11, 2'b01);
    vt[18] = mk(2'b00, 2'b01, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[19] = mk(2'b00, 2'b00, 2'b00, BUSY,   0, 0, 32'h80, 32'h0,  2'b11, 2'b11);
    vt[20] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[21] = mk(2'b00, 2'b11, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);
    vt[22] = mk(2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 32'h80, 32'h0,  2'b11, 2'b10);
    vt[23] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,  32'h0,  2'b11, 2'b11);

    do_reset();
    @(negedge CLK);
    chk("reset iwait", 64'(iwait), 64'h3);
    chk("reset dwait", 64'(dwait), 64'h3);
    chk("reset ramREN", 64'(ramREN), 64'h0);
    chk("reset ramWEN", 64'(ramWEN), 64'h0);
    chk("reset ramaddr", 64'(ramaddr), 64'h0);
    adv();

    for (int k = 0; k < 24; k++) begin
      ramload = $urandom;
      tick(vt[k].iren, vt[k].dren, vt[k].dwen, vt[k].rs);
      chk($sformatf("vec%0d ramREN", k), 64'(ramREN), 64'(vt[k].ren));
      chk($sformatf("vec%0d ramWEN", k), 64'(ramWEN), 64'(vt[k].wen));
      chk($sformatf("vec%0d ramaddr", k), 64'(ramaddr), 64'(vt[k].addr));
      chk($sformatf("vec%0d ramstore", k), 64'(ramstore), 64'(vt[k].store));
      chk($sformatf("vec%0d iwait", k), 64'(iwait), 64'(vt[k].iw));
      chk($sformatf("vec%0d dwait", k), 64'(dwait), 64'(vt[k].dw));
      chk($sformatf("vec%0d iload", k), 64'(iload[k % 2]), 64'(ramload));
      chk($sformatf("vec%0d dload", k), 64'(dload[(k + 1) % 2]), 64'(ramload));
      adv();
    end

    // Sustained dcache 0 traffic with icache 1 waiting: four data acks, then fetch.
    for (int n = 0; n < 6; n++) begin
      tick(2'b10, 2'b01, 2'b00, FREE);
      adv();
      tick(2'b10, 2'b01, 2'b00, ACCESS);
      if (n == 4) begin
        chk($sformatf("starve%0d iwait", n), 64'(iwait), 64'h1);
        chk($sformatf("starve%0d dwait", n), 64'(dwait), 64'h3);
        chk($sformatf("starve%0d ramaddr", n), 64'(ramaddr), 64'h44);
      end else begin
        chk($sformatf("starve%0d iwait", n), 64'(iwait), 64'h3);
        chk($sformatf("starve%0d dwait", n), 64'(dwait), 64'h2);
        chk($sformatf("starve%0d ramaddr", n), 64'(ramaddr), 64'h80);
      end
      $display("[TB] starve xfer %0d iwait=%b dwait=%b ramaddr=%0h", n, iwait, dwait, ramaddr);
      adv();
    end

    // Reset in the middle of a transfer, then the first tie goes to core 0.
    tick(2'b11, 2'b00, 2'b00, FREE);
    adv();
    tick(2'b11, 2'b00, 2'b00, BUSY);
    chk("pre-reset ramREN", 64'(ramREN), 64'h1);
    #1 nRST = 1'b0;
    #1;
    chk("async reset ramREN", 64'(ramREN), 64'h0);
    chk("async reset ramWEN", 64'(ramWEN), 64'h0);
    chk("async reset iwait", 64'(iwait), 64'h3);
    chk("async reset dwait", 64'(dwait), 64'h3);
    adv();
    nRST = 1'b1;
    tick(2'b11, 2'b00, 2'b00, FREE);
    adv();
    tick(2'b11, 2'b00, 2'b00, BUSY);
    chk("post-reset tie ramaddr", 64'(ramaddr), 64'h40);
    chk("post-reset tie ramREN", 64'(ramREN), 64'h1);
    adv();

    // Randomized traffic: caches hold requests until acked, occasionally withdraw.
    do_reset();
    m_busy = 1'b0; m_dcls = 1'b0; m_core = 0; m_last = CPUS - 1; m_starve = 0;
    ih = '0; dr_h = '0; dw_h = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
      end
      ramload = $urandom;
      tick(ih, dr_h, dw_h, ramstate_t'($urandom_range(0, 3)));

      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      e_iw = 2'b11; e_dw = 2'b11; act = 1'b0;
      if (m_busy) begin
        if (!m_dcls) begin
          act = iREN[m_core]; e_ren = act; e_addr = iaddr[m_core];
          if (act && ramstate == ACCESS) e_iw[m_core] = 1'b0;
        end else begin
          act = dREN[m_core] | dWEN[m_core];
          e_wen = dWEN[m_core]; e_ren = dREN[m_core] & ~dWEN[m_core];
          e_addr = daddr[m_core];
          e_store = dWEN[m_core] ? dstore[m_core] : 32'h0;
          if (act && ramstate == ACCESS) e_dw[m_core] = 1'b0;
        end
      end
      chk($sformatf("rnd%0d ramREN", cyc), 64'(ramREN), 64'(e_ren));
      chk($sformatf("rnd%0d ramWEN", cyc), 64'(ramWEN), 64'(e_wen));
      chk($sformatf("rnd%0d ramaddr", cyc), 64'(ramaddr), 64'(e_addr));
      chk($sformatf("rnd%0d ramstore", cyc), 64'(ramstore), 64'(e_store));
      chk($sformatf("rnd%0d iwait", cyc), 64'(iwait), 64'(e_iw));
      chk($sformatf("rnd%0d dwait", cyc), 64'(dwait), 64'(e_dw));
      chk($sformatf("rnd%0d iload", cyc), 64'(iload[cyc % 2]), 64'(ramload));

      if (!m_busy) begin
        if ((iREN | dREN | dWEN) != 2'b00) begin
          if (m_starve == SMAX && iREN != 2'b00) m_dcls = 1'b0;
          else if ((dREN | dWEN) != 2'b00) m_dcls = 1'b1;
          else m_dcls = 1'b0;
          m_core = first_from(m_dcls ? (dREN | dWEN) : iREN, m_last);
          m_busy = 1'b1;
        end
      end else if (!act) begin
        m_busy = 1'b0;
      end else if (ramstate == ACCESS) begin
        m_busy = 1'b0;
        m_last = m_core;
        if (!m_dcls) m_starve = 0;
        else if (iREN != 2'b00) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
      end

      for (int c = 0; c < CPUS; c++) begin
        if (!e_iw[c]) ih[c] = 1'b0;
        else if (ih[c]) ih[c] = ($urandom_range(0, 19) != 0);
        else ih[c] = ($urandom_range(0, 2) == 0);
        if (!e_dw[c]) begin
          dr_h[c] = 1'b0; dw_h[c] = 1'b0;
        end else if (dr_h[c] || dw_h[c]) begin
          if ($urandom_range(0, 19) == 0) begin
            dr_h[c] = 1'b0; dw_h[c] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0: dr_h[c] = 1'b1;
            1: dw_h[c] = 1'b1;
            default: begin dr_h[c] = 1'b1; dw_h[c] = 1'b1; end
          endcase
        end
      end
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
